stream_comp_packet_loader: RTL and testbench
============================================

// Module: stream_comp_packet_loader
// PURPOSE
//  Upstream producer for the stream-compute actor. Parses a word stream into packets
//  [command, length L, L data words] and writes them into the command, length and data FIFOs.
//  A header is released only when all L data words are guaranteed to fit, so an enabled
//  downstream firing never stalls on partial data. Malformed packets are dropped.
// PARAMETERS
//  width        10  word width of the input stream and of all FIFO data ports
//  buffer_size  10  depth of the command, length and data FIFOs; also the maximum legal L
// PORTS
//  clk            in   1            rising-edge clock
//  rst            in   1            async active-high reset
//  in_valid       in   1            upstream word valid
//  in_data        in   width        upstream word
//  in_ready       out  1            loader accepts in_data this cycle (comb)
//  pop_command    in   log2(bs)     command FIFO population
//  pop_length     in   log2(bs)     length FIFO population
//  pop_data       in   log2(bs)     data FIFO population
//  wr_en_command  out  1            command FIFO write strobe
//  wr_en_length   out  1            length FIFO write strobe
//  wr_en_data     out  1            data FIFO write strobe
//  command_out    out  width        command FIFO write data
//  length_out     out  width        length FIFO write data
//  data_out       out  width        data FIFO write data
//  pkt_count      out  width        packets fully written, wraps at 2^width
//  err            out  1            sticky: a packet was dropped
// BEHAVIOUR
//  Handshake: a word transfers on a clk edge when in_valid & in_ready.
//  FSM states and transitions:
//   CMD : in_ready=1; on transfer latch cmd_reg, go to LEN.
//   LEN : L = in_data.
//         L==0 or L>buffer_size -> in_ready=1; on transfer set err;
//           L==0 goes to CMD, otherwise latch rem=L and go to DROP.
//         Legal L -> in_ready = (pop_command<bs) & (pop_length<bs) & (bs-pop_data >= L).
//           On transfer, pulse wr_en_command and wr_en_length with command_out=cmd_reg and
//           length_out=L in the same cycle, latch rem=L, go to DATA.
//   DATA: in_ready=1, because space was reserved (only this block writes the data FIFO).
//         On transfer, wr_en_data=1 and data_out=in_data (comb pass-through); rem decrements.
//         When rem reaches 0, pkt_count increments and the FSM returns to CMD.
//   DROP: in_ready=1; each transfer decrements rem with no FIFO write; at rem 0 go to CMD.
//  Write strobes are combinational: strobe = transfer & state condition. FIFO data ports
//   are stable while their strobe is high. At most one strobe group is active per cycle.
//  Consumer reads during LEN only increase free space; the ready check uses current pops.
//  Reset (async, any state, including mid-packet): FSM=CMD, rem=0, cmd_reg=0, pkt_count=0,
//   err=0, all wr_en=0, in_ready=1 once rst deasserts. Any partially written packet is
//   abandoned; the FIFOs reset with the same rst.
//  Throughput: one word per cycle when not back-pressured. Header-to-first-data: 1 cycle.
// TESTING
//  T1 stream 3,4,1,2,3,4 into empty FIFOs -> cmd FIFO {3}, len FIFO {4}, data FIFO
//     {1,2,3,4}; pkt_count=1; err=0.
//  T2 pop_data=8, bs=10, header L=3 -> in_ready=0 in LEN until pop_data<=7, then the header
//     is written and 3 data words follow back-to-back.
//  T3 stream 5,0 then 6,1,9 -> err=1, no writes for packet 1; packet 2 written; pkt_count=1.
//  T4 stream 2,12 followed by 12 words (L>bs) -> all 12 words consumed with no writes, err=1,
//     FSM back in CMD; next packet loads normally.
//  T5 assert rst after 2 of 4 data words -> outputs reset immediately, pkt_count=0, err=0,
//     next word is parsed as a command.
//  T6 pop_command=bs (full) with a legal header -> stalls in LEN; writes both header words
//     in one cycle after one command pop.

Source files
------------

// File: rtl/stream_comp_packet_loader.sv
// Packet loader: parses [command, length L, L data words] from a valid/ready word stream
// and writes them into the command, length and data FIFOs. The header is released only
// once all L data words are known to fit, so data follows the header without stalling.
// Malformed packets (L == 0 or L > BufferSize) are consumed and dropped, setting a sticky err.
module stream_comp_packet_loader #(
    parameter int unsigned Width      = 10,
    parameter int unsigned BufferSize = 10,
    parameter int unsigned PopW       = $clog2(BufferSize + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    input  logic [Width-1:0] i_in_data,
    output logic             o_in_ready,
    input  logic [PopW-1:0]  i_pop_command,
    input  logic [PopW-1:0]  i_pop_length,
    input  logic [PopW-1:0]  i_pop_data,
    output logic             o_wr_en_command,
    output logic             o_wr_en_length,
    output logic             o_wr_en_data,
    output logic [Width-1:0] o_command_out,
    output logic [Width-1:0] o_length_out,
    output logic [Width-1:0] o_data_out,
    output logic [Width-1:0] o_pkt_count,
    output logic             o_err
);

    typedef enum logic [1:0] {StCmd, StLen, StData, StDrop} state_e;

    state_e           r_state;
    logic [Width-1:0] r_cmd;
    logic [Width-1:0] r_rem;
    logic [Width-1:0] r_pkt_count;
    logic             r_err;

    logic w_len_zero;
    logic w_len_big;
    logic w_len_legal;
    logic w_space_ok;
    logic w_ready;
    logic w_xfer;
    logic w_rem_last;

    assign w_len_zero  = (i_in_data == '0);
    assign w_len_big   = (32'(i_in_data) > BufferSize);
    assign w_len_legal = !w_len_zero && !w_len_big;
    // Free data space is BufferSize - pop_data; phrased as a sum to avoid underflow.
    assign w_space_ok  = (32'(i_pop_command) < BufferSize) &&
                         (32'(i_pop_length) < BufferSize) &&
                         ((32'(i_in_data) + 32'(i_pop_data)) <= BufferSize);
    assign w_rem_last  = (r_rem == Width'(1));

    // Ready decode: only a legal header can be held back, waiting for FIFO space.
    always_comb begin
        w_ready = 1'b1;
        case (r_state)
            StLen:   w_ready = w_len_legal ? w_space_ok : 1'b1;
            default: w_ready = 1'b1;
        endcase
    end

    assign w_xfer     = i_in_valid & w_ready;
    assign o_in_ready = w_ready;

    // Header strobes fire together; data strobe is a pass-through of the accepted word.
    assign o_wr_en_command = w_xfer && (r_state == StLen) && w_len_legal;
    assign o_wr_en_length  = o_wr_en_command;
    assign o_wr_en_data    = w_xfer && (r_state == StData);
    assign o_command_out   = r_cmd;
    assign o_length_out    = i_in_data;
    assign o_data_out      = i_in_data;
    assign o_pkt_count     = r_pkt_count;
    assign o_err           = r_err;

    // Parser FSM with remaining-word counter, packet counter and sticky error.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StCmd;
            r_cmd       <= '0;
            r_rem       <= '0;
            r_pkt_count <= '0;
            r_err       <= 1'b0;
        end else if (w_xfer) begin
            case (r_state)
                StCmd: begin
                    r_cmd   <= i_in_data;
                    r_state <= StLen;
                end
                StLen: begin
                    if (w_len_zero) begin
                        r_err   <= 1'b1;
                        r_state <= StCmd;
                    end else if (w_len_big) begin
                        r_err   <= 1'b1;
                        r_rem   <= i_in_data;
                        r_state <= StDrop;
                    end else begin
                        r_rem   <= i_in_data;
                        r_state <= StData;
                    end
                end
                StData: begin
                    r_rem <= r_rem - Width'(1);
                    if (w_rem_last) begin
                        r_pkt_count <= r_pkt_count + Width'(1);
                        r_state     <= StCmd;
                    end
                end
                StDrop: begin
                    r_rem <= r_rem - Width'(1);
                    if (w_rem_last) begin
                        r_state <= StCmd;
                    end
                end
                default: r_state <= StCmd;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_comp_packet_loader.sv
// Self-checking bench for stream_comp_packet_loader: expected FIFO writes are queued when
// stimulus is driven and matched against the write strobes as the DUT produces them.
module tb_stream_comp_packet_loader;

    localparam int unsigned W  = 10;
    localparam int unsigned BS = 10;
    localparam int unsigned PW = $clog2(BS + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic [PW-1:0] pop_command = '0;
    logic [PW-1:0] pop_length = '0;
    logic [PW-1:0] pop_data = '0;
    logic          wr_en_command, wr_en_length, wr_en_data;
    logic [W-1:0]  command_out, length_out, data_out, pkt_count;
    logic          err;

    int checks = 0;
    int errors = 0;
    int exp_pkts = 0;

    logic [W-1:0] q_cmd[$];
    logic [W-1:0] q_len[$];
    logic [W-1:0] q_dat[$];

    always #5 clk = ~clk;

    stream_comp_packet_loader #(.Width(W), .BufferSize(BS)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_in_valid      (in_valid),
        .i_in_data       (in_data),
        .o_in_ready      (in_ready),
        .i_pop_command   (pop_command),
        .i_pop_length    (pop_length),
        .i_pop_data      (pop_data),
        .o_wr_en_command (wr_en_command),
        .o_wr_en_length  (wr_en_length),
        .o_wr_en_data    (wr_en_data),
        .o_command_out   (command_out),
        .o_length_out    (length_out),
        .o_data_out      (data_out),
        .o_pkt_count     (pkt_count),
        .o_err           (err)
    );

    // Scoreboard: strobes are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en_command || wr_en_length) begin
                checks++;
                if (wr_en_command !== wr_en_length) begin
                    errors++;
                    $display("FAIL hdr_pair: cmd_en=%b len_en=%b, required equal",
                             wr_en_command, wr_en_length);
                end
            end
            if (wr_en_data && wr_en_command) begin
                checks++;
                errors++;
                $display("FAIL one_group: data and header strobes both high");
            end
            if (wr_en_command) begin
                checks++;
                if (q_cmd.size() == 0) begin
                    errors++;
                    $display("FAIL cmd_write: unexpected write of %0d", command_out);
                end else begin
                    logic [W-1:0] e;
                    e = q_cmd.pop_front();
                    if (command_out !== e) begin
                        errors++;
                        $display("FAIL cmd_write: got %0d, required %0d", command_out, e);
                    end
                end
            end
            if (wr_en_length) begin
                checks++;
                if (q_len.size() == 0) begin
                    errors++;
                    $display("FAIL len_write: unexpected write of %0d", length_out);
                end else begin
                    logic [W-1:0] e;
                    e = q_len.pop_front();
                    if (length_out !== e) begin
                        errors++;
                        $display("FAIL len_write: got %0d, required %0d", length_out, e);
                    end
                end
            end
            if (wr_en_data) begin
                checks++;
                if (q_dat.size() == 0) begin
                    errors++;
                    $display("FAIL data_write: unexpected write of %0d", data_out);
                end else begin
                    logic [W-1:0] e;
                    e = q_dat.pop_front();
                    if (data_out !== e) begin
                        errors++;
                        $display("FAIL data_write: got %0d, required %0d", data_out, e);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the word has transferred.
    task automatic put_word(input logic [W-1:0] w);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL put_word_timeout: word %0d not accepted, ready=%b", w, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_pkt(input logic [W-1:0] c, input logic [W-1:0] l,
                              input logic [W-1:0] d0);
        q_cmd.push_back(c);
        q_len.push_back(l);
        for (int i = 0; i < int'(l); i++) q_dat.push_back(d0 + W'(i));
        exp_pkts++;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || wr_en_command !== 1'b0 || wr_en_length !== 1'b0 ||
            wr_en_data !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: ready=%b en=%b%b%b, required 1 000", in_ready,
                     wr_en_command, wr_en_length, wr_en_data);
        end
        checks++;
        if (pkt_count !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_stat: pkt=%0d err=%b, required 0 0", pkt_count, err);
        end
    endtask

    task automatic test_basic();
        expect_pkt(3, 4, 1);
        put_word(3);
        put_word(4);
        for (int i = 1; i <= 4; i++) put_word(W'(i));
        checks++;
        if (pkt_count !== W'(exp_pkts) || err !== 1'b0) begin
            errors++;
            $display("FAIL basic_stat: pkt=%0d err=%b, required %0d 0", pkt_count, err, exp_pkts);
        end
        checks++;
        if (q_cmd.size() + q_len.size() + q_dat.size() != 0) begin
            errors++;
            $display("FAIL basic_drain: %0d writes outstanding, required 0",
                     q_cmd.size() + q_len.size() + q_dat.size());
        end
    endtask

    task automatic test_backpressure();
        pop_data = 8;
        expect_pkt(7, 3, 11);
        put_word(7);
        // Exactly-fits boundary: 10 - 8 >= 2.
        in_data = 2;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_fit: ready=%b for L=2 pop_data=8, required 1", in_ready);
        end
        in_data  = 3;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall: ready=%b for L=3 pop_data=8, required 0", in_ready);
            end
        end
        @(posedge clk);
        #1;
        pop_data = 7;
        put_word(3);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_data_ready: ready=%b, required 1", in_ready);
            end
            put_word(W'(11 + i));
        end
        pop_data = 0;
        checks++;
        if (pkt_count !== W'(exp_pkts) || q_dat.size() != 0) begin
            errors++;
            $display("FAIL bp_stat: pkt=%0d left=%0d, required %0d 0", pkt_count,
                     q_dat.size(), exp_pkts);
        end
    endtask

    task automatic test_drop_zero();
        put_word(5);
        put_word(0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL zero_err: err=%b, required 1", err);
        end
        expect_pkt(6, 1, 9);
        put_word(6);
        put_word(1);
        put_word(9);
        checks++;
        if (pkt_count !== W'(exp_pkts) || err !== 1'b1 || q_dat.size() != 0) begin
            errors++;
            $display("FAIL zero_stat: pkt=%0d err=%b left=%0d, required %0d 1 0", pkt_count,
                     err, q_dat.size(), exp_pkts);
        end
    endtask

    task automatic test_drop_long();
        put_word(2);
        put_word(12);
        for (int i = 0; i < 12; i++) put_word(W'(100 + i));
        expect_pkt(4, 2, 20);
        put_word(4);
        put_word(2);
        put_word(20);
        put_word(21);
        checks++;
        if (pkt_count !== W'(exp_pkts) || err !== 1'b1 || q_dat.size() != 0) begin
            errors++;
            $display("FAIL long_stat: pkt=%0d err=%b left=%0d, required %0d 1 0", pkt_count,
                     err, q_dat.size(), exp_pkts);
        end
        // Largest legal length into an empty data FIFO.
        expect_pkt(8, 10, 200);
        put_word(8);
        put_word(10);
        for (int i = 0; i < 10; i++) put_word(W'(200 + i));
        checks++;
        if (pkt_count !== W'(exp_pkts) || q_dat.size() != 0) begin
            errors++;
            $display("FAIL maxlen_stat: pkt=%0d left=%0d, required %0d 0", pkt_count,
                     q_dat.size(), exp_pkts);
        end
    endtask

    task automatic test_reset_mid();
        q_cmd.push_back(1);
        q_len.push_back(4);
        q_dat.push_back(50);
        q_dat.push_back(51);
        put_word(1);
        put_word(4);
        put_word(50);
        put_word(51);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pkt_count !== '0 || err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst: pkt=%0d err=%b ready=%b, required 0 0 1", pkt_count, err,
                     in_ready);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        exp_pkts = 0;
        @(posedge clk);
        #1;
        expect_pkt(9, 1, 60);
        put_word(9);
        put_word(1);
        put_word(60);
        checks++;
        if (pkt_count !== W'(exp_pkts) || q_cmd.size() + q_dat.size() != 0) begin
            errors++;
            $display("FAIL midrst_next: pkt=%0d left=%0d, required %0d 0", pkt_count,
                     q_cmd.size() + q_dat.size(), exp_pkts);
        end
    endtask

    task automatic test_cmd_full();
        pop_command = PW'(BS);
        expect_pkt(5, 2, 30);
        put_word(5);
        in_data  = 2;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL cmdfull_stall: ready=%b, required 0", in_ready);
            end
        end
        @(posedge clk);
        #1;
        pop_command = PW'(BS - 1);
        pop_length  = PW'(BS);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lenfull_stall: ready=%b, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        pop_length = PW'(BS - 1);
        put_word(2);
        put_word(30);
        put_word(31);
        pop_command = 0;
        pop_length  = 0;
        checks++;
        if (pkt_count !== W'(exp_pkts) || q_cmd.size() + q_len.size() + q_dat.size() != 0) begin
            errors++;
            $display("FAIL cmdfull_stat: pkt=%0d left=%0d, required %0d 0", pkt_count,
                     q_cmd.size() + q_len.size() + q_dat.size(), exp_pkts);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_drop_zero();
        test_drop_long();
        test_reset_mid();
        test_cmd_full();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
